// File: rtl/counter_pkg.sv
// Shared definitions for the counter/timer family.
//   DEFAULT_WIDTH  default counter and load width in bits
//   timer_state_e  control states of the countdown timer
package counter_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } timer_state_e;

endpackage : counter_pkg

// File: rtl/countdown_timer.sv
// Loadable down-counter / timer.
// A start value is taken through a valid/ready handshake while idle. The timer
// then counts down to zero on enabled cycles and raises a one-cycle done pulse
// at terminal count. In periodic mode it reloads and keeps running, which gives
// a tick every L+1 enabled cycles.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-low reset
//   load_valid   load_value is offered
//   load_ready   timer can accept a load (idle)
//   load_value   start/reload value
//   auto_reload  captured with the load; 1 = periodic mode
//   enable       count permit; 0 pauses count and state
//   abort        stop a running count and return to idle
//   count        current count
//   busy         timer is running
//   done         registered one-cycle terminal-count pulse
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | waiting for a load; count holds its last value
// ST_RUN  | counting down on enabled cycles
module countdown_timer
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             auto_reload,
  input  logic             enable,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  timer_state_e     state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic             done_q, done_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      mode_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    done_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // load_ready is 1 here, so load_valid alone completes the handshake.
        if (load_valid) begin
          count_d  = load_value;
          reload_d = load_value;
          mode_d   = auto_reload;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (enable) begin
          if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
          end else begin
            // The zero cycle itself is the terminal count; never wrap.
            done_d = 1'b1;
            if (mode_q) begin
              count_d = reload_q;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign load_ready = (state_q == ST_IDLE);
  assign busy       = (state_q == ST_RUN);
  assign count      = count_q;
  assign done       = done_q;

endmodule : countdown_timer

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         load_valid;
  logic         load_ready;
  logic [W-1:0] load_value;
  logic         auto_reload;
  logic         enable;
  logic         abort;
  logic [W-1:0] count;
  logic         busy;
  logic         done;

  always #5 clk = ~clk;

  countdown_timer #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_value  (load_value),
    .auto_reload (auto_reload),
    .enable      (enable),
    .abort       (abort),
    .count       (count),
    .busy        (busy),
    .done        (done)
  );

  typedef struct {
    int count;
    bit busy;
    bit ready;
    bit done;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   chk_no_wrap = 1'b0;

  // Reference model: a running timer is described by how many enabled cycles
  // remain until terminal count (including the zero cycle); the visible count
  // is one less than that.
  bit m_run      = 1'b0;
  int m_left     = 0;
  int m_reload   = 0;
  bit m_periodic = 1'b0;
  int m_idle_cnt = 0;
  bit m_done     = 1'b0;

  function automatic void check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_step(bit rst, bit lv, int lval, bit ar, bit en, bit ab);
    exp_t e;
    m_done = 1'b0;
    if (!rst) begin
      m_run      = 1'b0;
      m_idle_cnt = 0;
      m_reload   = 0;
      m_periodic = 1'b0;
    end else if (!m_run) begin
      if (lv) begin
        m_run      = 1'b1;
        m_reload   = lval;
        m_periodic = ar;
        m_left     = lval + 1;
      end
    end else if (ab) begin
      m_run      = 1'b0;
      m_idle_cnt = m_left - 1;
    end else if (en) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1'b1;
        if (m_periodic) m_left = m_reload + 1;
        else begin
          m_run      = 1'b0;
          m_idle_cnt = 0;
        end
      end
    end
    e.count = m_run ? (m_left - 1) : m_idle_cnt;
    e.busy  = m_run;
    e.ready = !m_run;
    e.done  = m_done;
    sb_q.push_back(e);
  endfunction

  // One clock cycle: drive inputs, let the model follow the edge, return on
  // the falling edge where the monitor samples.
  task automatic cyc(bit rst = 1, bit lv = 0, int lval = 0, bit ar = 0,
                     bit en = 0, bit ab = 0);
    reset       = rst;
    load_valid  = lv;
    load_value  = W'(lval);
    auto_reload = ar;
    enable      = en;
    abort       = ab;
    @(posedge clk);
    model_step(rst, lv, lval, ar, en, ab);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check("count", int'(count), e.count);
      check("busy", int'(busy), int'(e.busy));
      check("load_ready", int'(load_ready), int'(e.ready));
      check("done", int'(done), int'(e.done));
      if (chk_no_wrap) check("no_wrap", int'(count == {W{1'b1}}), 0);
    end
  end

  initial begin
    int lat;
    int n_en;
    int pulses;
    bit en_t;

    reset = 1'b0; load_valid = 1'b0; load_value = '0;
    auto_reload = 1'b0; enable = 1'b0; abort = 1'b0;
    @(negedge clk);

    // Power-up reset.
    cyc(0);
    cyc(0);
    check("reset_ready", int'(load_ready), 1);

    // 1: reset mid-run at count 5.
    cyc(1, 1, 8, 0, 0, 0);
    repeat (3) cyc(1, 0, 0, 0, 1, 0);
    check("t1_pre_count", int'(count), 5);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    check("t1_count", int'(count), 0);
    check("t1_ready", int'(load_ready), 1);
    cyc(1);

    // 2: one-shot load 4, done 5 cycles after the load edge.
    cyc(1, 1, 4, 0, 1, 0);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1, 0, 0, 0, 1, 0);
      lat++;
      if (done) break;
    end
    check("t2_latency", lat, 5);
    check("t2_busy_falls", int'(busy), 0);
    repeat (2) cyc(1, 0, 0, 0, 1, 0);

    // 3: periodic load 3, 12 enabled cycles -> 3 pulses.
    cyc(1, 1, 3, 1, 1, 0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1, 0, 0, 0, 1, 0);
      if (done) pulses++;
    end
    check("t3_pulses", pulses, 3);
    cyc(1, 0, 0, 0, 1, 1);

    // 4: load 6 with enable toggling; done on the 7th enabled cycle.
    cyc(1, 1, 6, 0, 0, 0);
    n_en = 0;
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      en_t = (i % 2 == 0);
      cyc(1, 0, 0, 0, en_t, 0);
      if (en_t) n_en++;
      if (done) begin
        lat = n_en;
        break;
      end
    end
    check("t4_enabled_cycles", lat, 7);

    // 5: load 9, abort at 5 while a new load is held pending.
    cyc(1, 1, 9, 0, 1, 0);
    for (int i = 0; i < 20 && count != 4'd5; i++) cyc(1, 1, 7, 0, 1, 0);
    check("t5_reached5", int'(count), 5);
    cyc(1, 1, 7, 0, 1, 1);
    check("t5_abort_count", int'(count), 5);
    check("t5_abort_busy", int'(busy), 0);
    cyc(1, 1, 7, 0, 0, 0);
    check("t5_reload_count", int'(count), 7);
    cyc(1, 0, 0, 0, 0, 1);

    // 6: load 0 one-shot; never wraps to all ones.
    chk_no_wrap = 1'b1;
    cyc(1, 1, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 1, 0);
    check("t6_done", int'(done), 1);
    repeat (3) cyc(1, 0, 0, 0, 1, 0);
    chk_no_wrap = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom_range(0, 99) != 0),
          $urandom_range(0, 1),
          $urandom_range(0, (1 << W) - 1),
          $urandom_range(0, 1),
          ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 9) == 0));
    end

    @(negedge clk);
    check("drain", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_countdown_timer
